// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master driver slice.
//   cmd_e       : 2-bit command field carried in the top bits of a command word
//   drv_state_e : driver FSM phases
//   FRAME_BITS  : width of a command word {cmd[1:0], payload[7:0]}
//   DATA_BITS   : width of a read-data reply
package spi_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEL,
        SHIFT,
        TURN,
        RECV,
        GAP
    } drv_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/spi_shift_rx.sv
// MSB-first serial-to-parallel converter.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : sample sdi on this edge
//   sdi        : serial input bit
//   data       : parallel word, updated on the edge that samples the last bit
//   done       : one-cycle pulse coincident with the data update
module spi_shift_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sdi,
    output logic [DATA_W-1:0] data,
    output logic              done
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            data <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                sr <= {sr[DATA_W-2:0], sdi};
                if (cnt == LAST) begin
                    // Publish the completed word including the bit sampled now.
                    data <= {sr[DATA_W-2:0], sdi};
                    done <= 1'b1;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_master_driver.sv
// Host-side SPI master: accepts 10-bit command words over valid/ready and
// serialises each as an SPI frame (START, select bit, 10 word bits). Read-data
// commands keep SS_n low through a turnaround and an 8-bit MISO reply.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready : command handshake, cmd_ready = FSM idle
//   cmd_word            : {cmd[1:0], payload[7:0]}
//   SS_n, MOSI, MISO    : SPI lines (MSB first)
//   rd_data, rd_valid   : last read-data reply and its one-cycle strobe
//   busy                : frame or inter-frame gap in progress
module spi_master_driver
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FRAME_BITS-1:0] cmd_word,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       SHIFT_LAST = 4'(FRAME_BITS - 1);

    drv_state_e            state, next_state;
    logic [FRAME_BITS-1:0] word_q;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [3:0]            bit_cnt;
    logic [CNT_W-1:0]      phase_cnt;
    logic                  rx_en;

    assign cmd_ready = (state == IDLE);
    assign rx_en     = (state == RECV);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (cmd_valid) next_state = START;
            START: next_state = SEL;
            SEL:   next_state = SHIFT;
            SHIFT: begin
                if (bit_cnt == SHIFT_LAST)
                    next_state = (cmd_e'(word_q[9:8]) == RD_DATA) ? TURN : GAP;
            end
            TURN:  if (phase_cnt == TURN_LAST) next_state = RECV;
            RECV:  if (phase_cnt == RECV_LAST) next_state = GAP;
            GAP:   if (phase_cnt == GAP_LAST)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Line outputs are registered from the current state, so each phase
    // appears on SS_n/MOSI one edge after the FSM enters it. busy is
    // registered from next_state so it tracks the state register exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_q    <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);

            if (state == IDLE && cmd_valid) begin
                word_q <= cmd_word;
                tx_sr  <= cmd_word;
            end

            if (state == SHIFT && next_state == SHIFT)
                bit_cnt <= bit_cnt + 1'b1;
            else
                bit_cnt <= '0;

            if (next_state != state)
                phase_cnt <= '0;
            else if (state == TURN || state == RECV || state == GAP)
                phase_cnt <= phase_cnt + 1'b1;

            SS_n <= !(state == START || state == SEL || state == SHIFT ||
                      state == TURN  || state == RECV);

            MOSI <= 1'b0;
            case (state)
                SEL:   MOSI <= word_q[FRAME_BITS-1];
                SHIFT: begin
                    MOSI  <= tx_sr[FRAME_BITS-1];
                    tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    spi_shift_rx #(
        .DATA_W (DATA_BITS)
    ) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rx_en),
        .sdi   (MISO),
        .data  (rd_data),
        .done  (rd_valid)
    );

endmodule

// File: tb/tb_spi_master_driver.sv
// Self-checking bench for spi_master_driver with a frame-level reference model.
module tb_spi_master_driver;

    localparam int TURN = 3;
    localparam int GAP  = 1;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_word;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    spi_master_driver #(
        .TURNAROUND (TURN),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_word  (cmd_word),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a frame is SS_n low for cycles 1..len after the accepting edge,
    // MOSI = {0, cmd[1], word[9:0]} then zeros; a read-data frame adds TURN idle
    // cycles and 8 reply cycles, the reply bits being sampled on edges
    // 13+TURN .. 20+TURN, with rd_valid on the last of them. The driver is busy
    // until GAP cycles after the frame ends.
    task automatic send(input logic [9:0] w, input logic [7:0] pat,
                        input int glitch_k, input int abort_k,
                        input bit hold, input logic [9:0] nxt, input bit immediate);
        int  waited, len, first_rx;
        bit  is_rd;
        logic exp_mosi;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        if (immediate) chk("b2b_wait", 32'(waited), 32'd0);
        cmd_valid = 1'b1;
        cmd_word  = w;
        tick();
        chk("ready_drop", 32'(cmd_ready), 32'd0);
        if (hold) cmd_word = nxt;
        else      cmd_valid = 1'b0;
        is_rd    = (w[9:8] == 2'b11);
        len      = is_rd ? 12 + TURN + 8 : 12;
        first_rx = 13 + TURN;
        for (int k = 1; k <= len + GAP; k++) begin
            if (k == glitch_k) begin
                cmd_valid = 1'b1;
                cmd_word  = 10'h0FF;
            end
            if (is_rd && k >= first_rx && k < first_rx + 8)
                MISO = pat[7 - (k - first_rx)];
            else
                MISO = 1'($urandom);
            if (k == abort_k) rst_n = 1'b0;
            tick();
            if (k == glitch_k) cmd_valid = 1'b0;
            if (k == abort_k) begin
                chk("abort_ss", 32'(SS_n), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(cmd_ready), 32'd1);
                chk("abort_rdv", 32'(rd_valid), 32'd0);
                rst_n = 1'b1;
                return;
            end
            if (k == 2)                 exp_mosi = w[9];
            else if (k >= 3 && k <= 12) exp_mosi = w[12 - k];
            else                        exp_mosi = 1'b0;
            chk($sformatf("ss_k%0d_w%0h", k, w), 32'(SS_n), 32'(!(k <= len)));
            chk($sformatf("mosi_k%0d_w%0h", k, w), 32'(MOSI), 32'(exp_mosi));
            chk($sformatf("rdv_k%0d_w%0h", k, w), 32'(rd_valid), 32'(is_rd && k == len));
            chk($sformatf("busy_k%0d_w%0h", k, w), 32'(busy), 32'(k < len + GAP));
            if (is_rd && k == len) chk($sformatf("rd_data_w%0h", w), 32'(rd_data), 32'(pat));
        end
        chk("idle_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic expect_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("quiet_ss", 32'(SS_n), 32'd1);
            chk("quiet_rdv", 32'(rd_valid), 32'd0);
        end
    endtask

    initial begin
        logic [9:0] w;
        logic [7:0] p;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_word  = '0;
        MISO      = 1'b0;
        repeat (3) tick();
        chk("rst_ss", 32'(SS_n), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed frames
        send(10'h02A, 8'h00, 0, 0, 1'b0, 10'h0, 1'b0);
        expect_quiet(3);
        send(10'h15C, 8'h00, 0, 0, 1'b0, 10'h0, 1'b0);
        send(10'h22A, 8'h00, 0, 0, 1'b0, 10'h0, 1'b0);
        send(10'h300, 8'h5C, 0, 0, 1'b0, 10'h0, 1'b0);
        send(10'h300, 8'hFF, 0, 0, 1'b0, 10'h0, 1'b0);
        send(10'h3C3, 8'hA5, 0, 0, 1'b0, 10'h0, 1'b0);

        // Back-to-back with cmd_valid held
        send(10'h1A5, 8'h00, 0, 0, 1'b1, 10'h0F0, 1'b0);
        send(10'h0F0, 8'h00, 0, 0, 1'b0, 10'h0, 1'b1);
        expect_quiet(4);

        // cmd_valid pulsed during SHIFT is ignored
        send(10'h133, 8'h00, 6, 0, 1'b0, 10'h0, 1'b0);
        expect_quiet(5);

        // Reset at k=7, then a normal frame
        send(10'h0AA, 8'h00, 0, 7, 1'b0, 10'h0, 1'b0);
        send(10'h055, 8'h00, 0, 0, 1'b0, 10'h0, 1'b0);

        // Randomised frames
        for (int i = 0; i < 24; i++) begin
            w = 10'($urandom);
            if (i % 3 == 0) w[9:8] = 2'b11;
            p = 8'($urandom);
            send(w, p, 0, 0, 1'b0, 10'h0, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        expect_quiet(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
